// File: rtl/uart_pkg.sv
// Shared receive-path types and constants for the UART receiver slice.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int BCLK_LENGTH_DEFAULT = 16;

    localparam logic [1:0] THR_GT8 = 2'b00;
    localparam logic [1:0] THR_GT6 = 2'b01;
    localparam logic [1:0] THR_GT4 = 2'b10;
    localparam logic [1:0] THR_GT2 = 2'b11;

    // FIFO fill level that must be exceeded for rx_thr to assert.
    function automatic int thr_limit(input logic [1:0] sel);
        case (sel)
            THR_GT8: thr_limit = 8;
            THR_GT6: thr_limit = 6;
            THR_GT4: thr_limit = 4;
            default: thr_limit = 2;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word fall-through output; pointers carry one extra
// wrap bit so that full and empty can be told apart from the count alone.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampling frame FSM feeding a receive FIFO with sticky errors.
// Define UART_RX_SYNC2_EN to pass rxd through a two-flop synchronizer first.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int BCLK_LENGTH = BCLK_LENGTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bclk,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       read_en,
    input  logic       err_clr,
    input  logic [1:0] rx_thr_val,
    output logic [7:0] data_out,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       rx_thr,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_bclk_en
);

    localparam int CW = $clog2(BCLK_LENGTH);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(BCLK_LENGTH / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BCLK_LENGTH - 1);

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift_reg, shift_n;
    logic          rxd_s;
    logic          push_req, set_parity, set_frame, set_overrun;
    logic [PW-1:0] fifo_count;

`ifdef UART_RX_SYNC2_EN
    logic [1:0] rxd_sync;

    always_ff @(posedge clk) begin
        if (reset) rxd_sync <= 2'b11;
        else       rxd_sync <= {rxd_sync[0], rxd};
    end

    assign rxd_s = rxd_sync[1];
`else
    assign rxd_s = rxd;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shift_reg <= shift_n;
        end
    end

    // START aligns sampling to mid-bit; every later sample is one full bit on.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_n      = bit_idx;
        shift_n    = shift_reg;
        push_req   = 1'b0;
        set_parity = 1'b0;
        set_frame  = 1'b0;
        if (!rx_en) begin
            state_n = IDLE;
            cnt_n   = '0;
            bit_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_n = START;
                        cnt_n   = '0;
                        bit_n   = '0;
                    end
                end
                START: begin
                    if (bclk) begin
                        if (cnt == HALF_LAST) begin
                            cnt_n   = '0;
                            state_n = rxd_s ? IDLE : DATA;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (bclk) begin
                        if (cnt == BIT_LAST) begin
                            cnt_n   = '0;
                            shift_n = {rxd_s, shift_reg[7:1]};
                            bit_n   = bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state_n = parity_en ? PARITY : STOP;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bclk) begin
                        if (cnt == BIT_LAST) begin
                            cnt_n      = '0;
                            set_parity = ((^shift_reg) ^ rxd_s) != parity_type;
                            state_n    = STOP;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bclk) begin
                        if (cnt == BIT_LAST) begin
                            cnt_n     = '0;
                            push_req  = rxd_s;
                            set_frame = !rxd_s;
                            state_n   = IDLE;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign rx_bclk_en  = (state != IDLE);
    assign set_overrun = push_req && rx_full && !read_en;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (read_en),
        .din   (shift_reg),
        .dout  (data_out),
        .count (fifo_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_thr = int'(fifo_count) > thr_limit(rx_thr_val);

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (set_parity)   parity_err  <= 1'b1;
            else if (err_clr) parity_err  <= 1'b0;
            if (set_frame)    frame_err   <= 1'b1;
            else if (err_clr) frame_err   <= 1'b0;
            if (set_overrun)  overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: frames are driven bit by bit
// on rxd with bclk pulsing every other clk, so one bit lasts 2*BCLK_LENGTH clks.
module tb_uart_receiver;

    localparam int FIFO_DEPTH  = 16;
    localparam int BCLK_LENGTH = 16;
    localparam int BIT_CLKS    = 2 * BCLK_LENGTH;

    logic       clk, reset, bclk, rxd, rx_en, parity_en, parity_type, read_en, err_clr;
    logic [1:0] rx_thr_val;
    logic [7:0] data_out;
    logic       rx_empty, rx_full, rx_thr, parity_err, frame_err, overrun_err, rx_bclk_en;

    int check_count = 0;
    int fail_count  = 0;

    uart_receiver #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BCLK_LENGTH (BCLK_LENGTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bclk        (bclk),
        .rxd         (rxd),
        .rx_en       (rx_en),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .read_en     (read_en),
        .err_clr     (err_clr),
        .rx_thr_val  (rx_thr_val),
        .data_out    (data_out),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .rx_thr      (rx_thr),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_bclk_en  (rx_bclk_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bclk = 1'b0;
        forever begin
            @(negedge clk);
            bclk = ~bclk;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_bit(input logic b, input int clks);
        rxd = b;
        repeat (clks) @(negedge clk);
    endtask

    // Stop bit is held just past its mid-bit sample, then the line idles high.
    task automatic send_frame(input logic [7:0] data, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
        if (with_par) drive_bit(par_bit, BIT_CLKS);
        drive_bit(stop_bit, 24);
        drive_bit(1'b1, 40);
    endtask

    task automatic pop_one();
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_count++; if (rx_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_empty: got %b expected 1", rx_empty); end
        check_count++; if (rx_full !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_full: got %b expected 0", rx_full); end
        check_count++; if (rx_thr !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_thr: got %b expected 0", rx_thr); end
        check_count++; if (data_out !== 8'h00) begin fail_count++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
        check_count++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin fail_count++; $display("[TB] FAIL reset_errors: got %b expected 000", {parity_err, frame_err, overrun_err}); end
        check_count++; if (rx_bclk_en !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_bclk_en: got %b expected 0", rx_bclk_en); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check_count++; if (data_out !== 8'hA5) begin fail_count++; $display("[TB] FAIL basic_data: got %h expected a5", data_out); end
        check_count++; if (rx_empty !== 1'b0) begin fail_count++; $display("[TB] FAIL basic_empty: got %b expected 0", rx_empty); end
        check_count++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin fail_count++; $display("[TB] FAIL basic_errors: got %b expected 000", {parity_err, frame_err, overrun_err}); end
        check_count++; if (rx_bclk_en !== 1'b0) begin fail_count++; $display("[TB] FAIL basic_idle: got %b expected 0", rx_bclk_en); end
        pop_one();
        check_count++; if (rx_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL basic_pop_empty: got %b expected 1", rx_empty); end
    endtask

    task automatic test_parity();
        parity_en   = 1'b1;
        parity_type = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        check_count++; if (parity_err !== 1'b0) begin fail_count++; $display("[TB] FAIL parity_even_ok: got %b expected 0", parity_err); end
        check_count++; if (data_out !== 8'h3C) begin fail_count++; $display("[TB] FAIL parity_even_data: got %h expected 3c", data_out); end
        pop_one();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check_count++; if (parity_err !== 1'b1) begin fail_count++; $display("[TB] FAIL parity_even_bad: got %b expected 1", parity_err); end
        check_count++; if (data_out !== 8'h3C) begin fail_count++; $display("[TB] FAIL parity_bad_pushed: got %h expected 3c", data_out); end
        check_count++; if (rx_empty !== 1'b0) begin fail_count++; $display("[TB] FAIL parity_bad_empty: got %b expected 0", rx_empty); end
        pop_one();
        pulse_clr();
        check_count++; if (parity_err !== 1'b0) begin fail_count++; $display("[TB] FAIL parity_clr: got %b expected 0", parity_err); end
        parity_type = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check_count++; if (parity_err !== 1'b0) begin fail_count++; $display("[TB] FAIL parity_odd_ok: got %b expected 0", parity_err); end
        pop_one();
        parity_en   = 1'b0;
        parity_type = 1'b0;
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        check_count++; if (rx_bclk_en !== 1'b1) begin fail_count++; $display("[TB] FAIL glitch_started: got %b expected 1", rx_bclk_en); end
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check_count++; if (rx_bclk_en !== 1'b0) begin fail_count++; $display("[TB] FAIL glitch_idle: got %b expected 0", rx_bclk_en); end
        check_count++; if (rx_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL glitch_no_push: got %b expected 1", rx_empty); end
        check_count++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin fail_count++; $display("[TB] FAIL glitch_errors: got %b expected 000", {parity_err, frame_err, overrun_err}); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check_count++; if (frame_err !== 1'b1) begin fail_count++; $display("[TB] FAIL frame_err_set: got %b expected 1", frame_err); end
        check_count++; if (rx_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL frame_err_discard: got %b expected 1", rx_empty); end
        pulse_clr();
        check_count++; if (frame_err !== 1'b0) begin fail_count++; $display("[TB] FAIL frame_err_clr: got %b expected 0", frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        rx_thr_val = 2'b00;
        for (int i = 0; i < 17; i++) begin
            exp = 8'h40 + 8'(i);
            send_frame(exp, 1'b0, 1'b0, 1'b1);
            if (i == 15) begin
                check_count++; if (rx_full !== 1'b1) begin fail_count++; $display("[TB] FAIL overrun_full16: got %b expected 1", rx_full); end
                check_count++; if (overrun_err !== 1'b0) begin fail_count++; $display("[TB] FAIL overrun_early: got %b expected 0", overrun_err); end
            end
        end
        check_count++; if (overrun_err !== 1'b1) begin fail_count++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun_err); end
        check_count++; if (rx_full !== 1'b1) begin fail_count++; $display("[TB] FAIL overrun_full: got %b expected 1", rx_full); end
        check_count++; if (rx_thr !== 1'b1) begin fail_count++; $display("[TB] FAIL overrun_thr: got %b expected 1", rx_thr); end
        for (int i = 0; i < 16; i++) begin
            exp = 8'h40 + 8'(i);
            check_count++; if (data_out !== exp) begin fail_count++; $display("[TB] FAIL overrun_read%0d: got %h expected %h", i, data_out, exp); end
            pop_one();
        end
        check_count++; if (rx_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL overrun_drained: got %b expected 1", rx_empty); end
        check_count++; if (rx_full !== 1'b0) begin fail_count++; $display("[TB] FAIL overrun_not_full: got %b expected 0", rx_full); end
        pulse_clr();
        check_count++; if (overrun_err !== 1'b0) begin fail_count++; $display("[TB] FAIL overrun_clr: got %b expected 0", overrun_err); end
    endtask

    task automatic test_threshold();
        rx_thr_val = 2'b11;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        check_count++; if (rx_thr !== 1'b0) begin fail_count++; $display("[TB] FAIL thr_two: got %b expected 0", rx_thr); end
        send_frame(8'h03, 1'b0, 1'b0, 1'b1);
        check_count++; if (rx_thr !== 1'b1) begin fail_count++; $display("[TB] FAIL thr_three: got %b expected 1", rx_thr); end
        pop_one();
        check_count++; if (rx_thr !== 1'b0) begin fail_count++; $display("[TB] FAIL thr_after_pop: got %b expected 0", rx_thr); end
        check_count++; if (data_out !== 8'h02) begin fail_count++; $display("[TB] FAIL thr_head: got %h expected 02", data_out); end
        pop_one();
        pop_one();
        rx_thr_val = 2'b00;
    endtask

    task automatic test_rx_en_abort();
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b0, 10);
        check_count++; if (rx_bclk_en !== 1'b1) begin fail_count++; $display("[TB] FAIL abort_active: got %b expected 1", rx_bclk_en); end
        rx_en = 1'b0;
        @(negedge clk);
        check_count++; if (rx_bclk_en !== 1'b0) begin fail_count++; $display("[TB] FAIL abort_idle: got %b expected 0", rx_bclk_en); end
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rx_en = 1'b1;
        repeat (BIT_CLKS * 10) @(negedge clk);
        check_count++; if (rx_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL abort_no_push: got %b expected 1", rx_empty); end
        check_count++; if (frame_err !== 1'b0) begin fail_count++; $display("[TB] FAIL abort_no_frame_err: got %b expected 0", frame_err); end
    endtask

    initial begin
        reset       = 1'b1;
        rxd         = 1'b1;
        rx_en       = 1'b1;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        read_en     = 1'b0;
        err_clr     = 1'b0;
        rx_thr_val  = 2'b00;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_threshold();
        test_rx_en_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entry count, power of two.
REQ-002 SHALL have parameter BCLK_LENGTH, default 16, bclk ticks per bit.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 bclk  input  1  one-clk pulse at BCLK_LENGTH x baud rate.
REQ-006 rxd  input  1  serial line, idle high.
REQ-007 rx_en  input  1  receiver enable; 0 holds the FSM in IDLE.
REQ-008 parity_en  input  1  parity bit present after data.
REQ-009 parity_type  input  1  1 = odd parity, 0 = even parity.
REQ-010 read_en  input  1  pop FIFO head.
REQ-011 err_clr  input  1  clear sticky error flags.
REQ-012 rx_thr_val  input  2  threshold select.
REQ-013 data_out  output  8  FIFO head, first-word fall-through.
REQ-014 rx_empty, rx_full  output  1 each  FIFO status.
REQ-015 rx_thr  output  1  FIFO count above threshold.
REQ-016 parity_err, frame_err, overrun_err  output  1 each  sticky error flags.
REQ-017 rx_bclk_en  output  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the counter advances only on cycles with bclk=1.
REQ-019 IDLE->START SHALL occur when rx_en=1 and the synchronized rxd=0; counter cleared.
REQ-020 In START, at counter==BCLK_LENGTH/2-1, rxd=0 -> DATA with counter cleared; rxd=1 -> IDLE (glitch reject).
REQ-021 In DATA, rxd SHALL be sampled at counter==BCLK_LENGTH-1, LSB first, 8 bits; after bit 7 go to PARITY if parity_en, else STOP.
REQ-022 PARITY SHALL sample one bit; parity_err sets if the XOR of the 8 data bits and the parity bit is 0 for odd or 1 for even.
REQ-023 STOP: sampled rxd=1 -> push byte, go IDLE; rxd=0 -> set frame_err, discard byte, go IDLE.
REQ-024 A byte with a parity error SHALL still be pushed.
REQ-025 Push while full with no same-cycle pop SHALL drop the byte and set overrun_err; a push with a simultaneous pop while full SHALL succeed.
REQ-026 Pop while empty SHALL be ignored; data_out is then don't-care.
REQ-027 Count SHALL be tracked with pointers one bit wider than log2(FIFO_DEPTH), which wrap modulo 2*FIFO_DEPTH.
REQ-028 rx_thr: 00 -> count>8, 01 -> count>6, 10 -> count>4, 11 -> count>2.
REQ-029 err_clr SHALL clear all flags; an error set in the same cycle SHALL win.
REQ-030 Deasserting rx_en mid-frame SHALL abort to IDLE with no push.
REQ-031 Pushed data SHALL appear on data_out with rx_empty=0 on the clk after the STOP sample.

Reset
REQ-032 On reset: FSM IDLE, counter 0, pointers 0, rx_empty=1, rx_full=0, rx_thr=0, all error flags 0, rx_bclk_en=0, data_out=0.
REQ-033 Reset mid-frame SHALL discard the partial byte; FIFO contents are lost.

Configuration
REQ-034 With UART_RX_SYNC2_EN defined, rxd SHALL pass through a two-flop synchronizer reset to 1, adding 2 clk latency; without it, rxd is used directly.

Structure
REQ-035 uart_pkg SHALL hold the rx state enum, BCLK_LENGTH default, and threshold encodings.
REQ-036 The FIFO SHALL be a sub-module uart_rx_fifo (push/pop/count/full/empty).

Verification
REQ-037 0xA5, no parity, valid stop -> data_out=0xA5, rx_empty=0, no error flags.
REQ-038 0x3C with even parity bit 0 -> no parity_err; same frame with parity bit 1 -> parity_err=1, byte 0x3C still pushed.
REQ-039 rxd low for 4 bclk ticks, then high -> FSM returns to IDLE, no push, no flags.
REQ-040 Stop bit 0 -> frame_err=1, FIFO unchanged; err_clr pulse -> frame_err=0.
REQ-041 17 frames with no reads -> rx_full=1, overrun_err=1, the first 16 bytes read back in order.
REQ-042 rx_thr_val=11, 3 bytes received -> rx_thr=1; one pop -> rx_thr=0.
